// File: rtl/move_sequencer.sv
// move_sequencer: debounce, arbitration and turn FSM in front of the 2048 board datapath.
// Optional MOVE_QUEUE_EN replaces the single pending-move register with a QDEPTH-entry FIFO.
module move_sequencer #(
    parameter int DB_CYCLES  = 16,
    parameter int TURN_WIDTH = 14,
    parameter int QDEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btnL,
    input  logic                  btnR,
    input  logic                  btnU,
    input  logic                  btnD,
    output logic                  move_valid,
    output logic [1:0]            move_dir,
    input  logic                  move_ready,
    input  logic                  move_done,
    input  logic                  move_changed,
    output logic                  spawn_req,
    input  logic                  spawn_done,
    input  logic                  game_over,
    output logic [TURN_WIDTH-1:0] turns,
    output logic                  busy,
    output logic                  locked,
    output logic                  dropped
);

    localparam int            CW     = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);

    if (DB_CYCLES < 2 || QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_params
        $error("move_sequencer: illegal DB_CYCLES or QDEPTH");
    end

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        WAIT,
        SPAWN,
        OVER
    } state_e;

    state_e state_q;

    // Bit index equals the direction code: 0=L, 1=R, 2=U, 3=D.
    logic [3:0] btn;
    assign btn = {btnD, btnU, btnR, btnL};

    logic [CW-1:0] db_cnt_q [4];
    logic [CW-1:0] db_cnt_d [4];
    logic [3:0]    db_lvl_q, db_lvl_d;
    logic [3:0]    press_q, press_d;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (!btn[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
                db_cnt_d[i] = DB_MAX;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + CW'(1);
            end
            db_lvl_d[i] = btn[i] && (db_cnt_d[i] == DB_MAX);
        end
        press_d = db_lvl_d & ~db_lvl_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            db_lvl_q <= '0;
            press_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            db_lvl_q <= db_lvl_d;
            press_q  <= press_d;
        end
    end

    // Fixed priority L > R > U > D: the lowest set bit wins.
    logic       win_valid;
    logic [1:0] win_dir;
    logic       multi_press;

    always_comb begin
        win_valid = 1'b0;
        win_dir   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press_q[i]) begin
                win_valid = 1'b1;
                win_dir   = 2'(i);
            end
        end
        multi_press = (press_q & (press_q - 4'd1)) != 4'd0;
    end

    logic       pend_valid;
    logic [1:0] pend_dir;
    logic       accept;
    logic       launch;
    logic       enter_over;

    assign enter_over = (state_q == IDLE) && game_over;
    assign launch     = (state_q == IDLE) && !game_over && pend_valid;

`ifdef MOVE_QUEUE_EN
    localparam int            PW   = $clog2(QDEPTH);
    localparam logic [PW:0]   FULL = (PW + 1)'(QDEPTH);

    logic [1:0]    fifo_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;

    assign pend_valid = (count_q != '0);
    assign pend_dir   = fifo_q[rd_ptr_q];
    // A full FIFO still takes a write when IDLE pops an entry in the same cycle.
    assign accept     = win_valid && (state_q != OVER) && !enter_over &&
                        ((count_q != FULL) || launch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (enter_over) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (launch) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({accept, launch})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; count_q gates every read, so stale entries are never used.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_q[wr_ptr_q] <= win_dir;
        end
    end
`else
    logic       pend_valid_q;
    logic [1:0] pend_dir_q;

    assign pend_valid = pend_valid_q;
    assign pend_dir   = pend_dir_q;
    assign accept     = win_valid && (state_q == IDLE) && !game_over && !pend_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_dir_q   <= 2'd0;
        end else if (enter_over || launch) begin
            pend_valid_q <= 1'b0;
        end else if (accept) begin
            pend_valid_q <= 1'b1;
            pend_dir_q   <= win_dir;
        end
    end
`endif

    logic                  move_valid_q;
    logic [1:0]            move_dir_q;
    logic                  spawn_req_q;
    logic [TURN_WIDTH-1:0] turns_q;
    logic                  busy_q;
    logic                  locked_q;
    logic                  dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            move_valid_q <= 1'b0;
            move_dir_q   <= 2'd0;
            spawn_req_q  <= 1'b0;
            turns_q      <= '0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            dropped_q <= multi_press || (win_valid && !accept);
            case (state_q)
                IDLE: begin
                    if (game_over) begin
                        state_q  <= OVER;
                        busy_q   <= 1'b1;
                        locked_q <= 1'b1;
                    end else if (pend_valid) begin
                        state_q      <= MOVE;
                        busy_q       <= 1'b1;
                        move_valid_q <= 1'b1;
                        move_dir_q   <= pend_dir;
                    end
                end
                MOVE: begin
                    if (move_ready) begin
                        state_q      <= WAIT;
                        move_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (move_done) begin
                        if (move_changed) begin
                            state_q     <= SPAWN;
                            spawn_req_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                SPAWN: begin
                    if (spawn_done) begin
                        state_q     <= IDLE;
                        spawn_req_q <= 1'b0;
                        busy_q      <= 1'b0;
                        if (turns_q != '1) begin
                            turns_q <= turns_q + TURN_WIDTH'(1);
                        end
                    end
                end
                OVER: begin
                    state_q <= OVER;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign move_valid = move_valid_q;
    assign move_dir   = move_dir_q;
    assign spawn_req  = spawn_req_q;
    assign turns      = turns_q;
    assign busy       = busy_q;
    assign locked     = locked_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed scenarios plus randomized turns checked against a turn-level model.
// Expectations for the pending-store scenario follow the MOVE_QUEUE_EN setting of the build.
module tb_move_sequencer;

    localparam int DB   = 16;
    localparam int TW   = 4;
    localparam int LAT  = DB + 2;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btnL, btnR, btnU, btnD;
    logic          move_valid;
    logic [1:0]    move_dir;
    logic          move_ready;
    logic          move_done;
    logic          move_changed;
    logic          spawn_req;
    logic          spawn_done;
    logic          game_over;
    logic [TW-1:0] turns;
    logic          busy;
    logic          locked;
    logic          dropped;

    move_sequencer #(
        .DB_CYCLES (DB),
        .TURN_WIDTH(TW),
        .QDEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btnL        (btnL),
        .btnR        (btnR),
        .btnU        (btnU),
        .btnD        (btnD),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .move_ready  (move_ready),
        .move_done   (move_done),
        .move_changed(move_changed),
        .spawn_req   (spawn_req),
        .spawn_done  (spawn_done),
        .game_over   (game_over),
        .turns       (turns),
        .busy        (busy),
        .locked      (locked),
        .dropped     (dropped)
    );

    always #5 clk = ~clk;

    int   checks      = 0;
    int   failures    = 0;
    int   mv_rises    = 0;
    int   drop_cycles = 0;
    logic mv_prev     = 1'b0;

    // Event counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (move_valid && !mv_prev) mv_rises <= mv_rises + 1;
        mv_prev <= move_valid;
        if (dropped) drop_cycles <= drop_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btns(input logic [3:0] mask);
        {btnD, btnU, btnR, btnL} = mask;
    endtask

    task automatic wait_valid(input int budget, output int edges);
        edges = 0;
        while (!move_valid && edges < budget) begin
            step(1);
            edges++;
        end
    endtask

    task automatic pulse_done(input logic changed);
        move_done    = 1'b1;
        move_changed = changed;
        step(1);
        move_done    = 1'b0;
        move_changed = 1'b0;
    endtask

    task automatic press_release(input logic [3:0] mask);
        set_btns(mask);
        step(DB + 2);
        set_btns(4'b0000);
        step(2);
    endtask

    // Priority rule: left beats right beats up beats down.
    function automatic int winner(input logic [3:0] m);
        if (m[0]) return 0;
        if (m[1]) return 1;
        if (m[2]) return 2;
        return 3;
    endfunction

    initial begin
        int         e;
        int         m0;
        int         d0;
        int         exp_drops;
        int         exp_order[$];
        int         model_turns;
        int         sat_turns;
        int         it;
        int         exp_dir;
        logic [3:0] mask;
        logic       chg;

        rst_n        = 1'b0;
        set_btns(4'b0000);
        move_ready   = 1'b1;
        move_done    = 1'b0;
        move_changed = 1'b0;
        spawn_done   = 1'b0;
        game_over    = 1'b0;
        step(3);

        check("rst_move_valid", 32'(move_valid), 0);
        check("rst_move_dir",   32'(move_dir),   0);
        check("rst_spawn_req",  32'(spawn_req),  0);
        check("rst_turns",      32'(turns),      0);
        check("rst_busy",       32'(busy),       0);
        check("rst_locked",     32'(locked),     0);
        check("rst_dropped",    32'(dropped),    0);
        rst_n = 1'b1;
        step(1);

        // Single right press through a board-changing turn.
        m0 = mv_rises;
        d0 = drop_cycles;
        btnR = 1'b1;
        wait_valid(40, e);
        check("t1_latency", 32'(e), 32'(LAT));
        check("t1_dir",     32'(move_dir), 1);
        step(1);
        check("t1_handshake_valid", 32'(move_valid), 0);
        check("t1_busy_wait",       32'(busy), 1);
        step(1);
        btnR = 1'b0;
        step(3);
        check("t1_one_valid",   32'(mv_rises - m0), 1);
        check("t1_no_spawn_yet", 32'(spawn_req), 0);
        pulse_done(1'b1);
        check("t1_spawn_req", 32'(spawn_req), 1);
        step(3);
        check("t1_spawn_hold", 32'(spawn_req), 1);
        check("t1_turns_hold", 32'(turns), 0);
        spawn_done = 1'b1;
        step(1);
        spawn_done = 1'b0;
        check("t1_turns",     32'(turns), 1);
        check("t1_busy_done", 32'(busy), 0);
        check("t1_spawn_off", 32'(spawn_req), 0);
        check("t1_no_drop",   32'(drop_cycles - d0), 0);

        // Glitches shorter than the debounce window.
        m0 = mv_rises;
        d0 = drop_cycles;
        btnU = 1'b1;
        step(DB - 1);
        btnU = 1'b0;
        step(1);
        btnU = 1'b1;
        step(DB - 1);
        btnU = 1'b0;
        step(4);
        check("t2_no_valid", 32'(mv_rises - m0), 0);
        check("t2_no_drop",  32'(drop_cycles - d0), 0);

        // Completion pulses outside WAIT/SPAWN are ignored.
        move_done    = 1'b1;
        move_changed = 1'b1;
        spawn_done   = 1'b1;
        step(1);
        move_done    = 1'b0;
        move_changed = 1'b0;
        spawn_done   = 1'b0;
        step(2);
        check("stray_spawn_req", 32'(spawn_req), 0);
        check("stray_busy",      32'(busy), 0);
        check("stray_turns",     32'(turns), 1);

        // Simultaneous left and down, then an unchanged board.
        m0 = mv_rises;
        d0 = drop_cycles;
        set_btns(4'b1001);
        wait_valid(40, e);
        check("t3_latency", 32'(e), 32'(LAT));
        check("t3_dir",     32'(move_dir), 0);
        check("t3_drop",    32'(drop_cycles - d0), 1);
        step(1);
        set_btns(4'b0000);
        step(2);
        pulse_done(1'b0);
        check("t4_busy",      32'(busy), 0);
        check("t4_no_spawn",  32'(spawn_req), 0);
        check("t4_turns",     32'(turns), 1);
        step(3);
        check("t4_one_valid", 32'(mv_rises - m0), 1);
        check("t4_no_spawn2", 32'(spawn_req), 0);

        // Presses during a stalled move.
        move_ready = 1'b0;
        btnL = 1'b1;
        wait_valid(40, e);
        check("t5_first_latency", 32'(e), 32'(LAT));
        btnL = 1'b0;
        step(2);
        d0 = drop_cycles;
        press_release(4'b0010);
        press_release(4'b0100);
        press_release(4'b1000);
        press_release(4'b0001);
        press_release(4'b0010);
`ifdef MOVE_QUEUE_EN
        exp_drops = 1;
        exp_order = '{1, 2, 3, 0};
`else
        exp_drops = 5;
`endif
        check("t5_drops",       32'(drop_cycles - d0), 32'(exp_drops));
        check("t5_valid_held",  32'(move_valid), 1);
        check("t5_dir_stable",  32'(move_dir), 0);
        m0 = mv_rises;
        move_ready = 1'b1;
        step(1);
        check("t5_handshake", 32'(move_valid), 0);
        foreach (exp_order[k]) begin
            pulse_done(1'b0);
            step(1);
            check("t5_queued_valid", 32'(move_valid), 1);
            check("t5_queued_dir",   32'(move_dir), 32'(exp_order[k]));
            step(1);
        end
        pulse_done(1'b0);
        step(3);
        check("t5_drained_valid", 32'(move_valid), 0);
        check("t5_drained_busy",  32'(busy), 0);
        check("t5_issued_count",  32'(mv_rises - m0), 32'(exp_order.size()));

        // Game over with a move already pending.
        m0 = mv_rises;
        d0 = drop_cycles;
        btnU = 1'b1;
        step(LAT - 1);
        game_over = 1'b1;
        step(1);
        check("t6_locked",   32'(locked), 1);
        check("t6_no_valid", 32'(move_valid), 0);
        check("t6_busy",     32'(busy), 1);
        btnU = 1'b0;
        step(2);
        press_release(4'b0010);
        press_release(4'b0110);
        check("t6_drops",      32'(drop_cycles - d0), 2);
        check("t6_no_valids",  32'(mv_rises - m0), 0);
        game_over = 1'b0;
        step(2);
        check("t6_sticky", 32'(locked), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_locked", 32'(locked), 0);
        check("t6_rst_turns",  32'(turns), 0);
        check("t6_rst_busy",   32'(busy), 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Random turns against the turn-level model, continuing past saturation.
        model_turns = 0;
        sat_turns   = 0;
        it          = 0;
        while ((it < 24 || sat_turns < 2) && it < 80) begin
            mask    = 4'($urandom_range(1, 15));
            exp_dir = winner(mask);
            m0      = mv_rises;
            d0      = drop_cycles;
            move_ready = 1'b0;
            set_btns(mask);
            wait_valid(40, e);
            check("rnd_latency", 32'(e), 32'(LAT));
            check("rnd_dir",     32'(move_dir), 32'(exp_dir));
            check("rnd_drop",    32'(drop_cycles - d0), ($countones(mask) > 1) ? 1 : 0);
            step($urandom_range(0, 3));
            check("rnd_valid_held", 32'(move_valid), 1);
            check("rnd_dir_stable", 32'(move_dir), 32'(exp_dir));
            move_ready = 1'b1;
            step(1);
            move_ready = 1'b0;
            check("rnd_handshake", 32'(move_valid), 0);
            set_btns(4'b0000);
            step($urandom_range(0, 3));
            chg = ($urandom_range(0, 3) != 0);
            pulse_done(chg);
            if (chg) begin
                check("rnd_spawn_req", 32'(spawn_req), 1);
                step($urandom_range(0, 3));
                spawn_done = 1'b1;
                step(1);
                spawn_done = 1'b0;
                if (model_turns == TMAX) sat_turns++;
                else model_turns++;
            end
            check("rnd_turns",     32'(turns), 32'(model_turns));
            check("rnd_busy",      32'(busy), 0);
            check("rnd_spawn_off", 32'(spawn_req), 0);
            step(2);
            check("rnd_one_valid", 32'(mv_rises - m0), 1);
            it++;
        end
        check("rnd_saturated", 32'(turns), 32'(TMAX));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
